// File: rtl/alu_pkg.sv
// Shared definitions for the small-ALU area (add/sub unit and the divider).
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
//
// Contents:
//   DEFAULT_WIDTH  default operand width used by the ALU blocks
//   state_t        divider control states (IDLE / RUN / DONE)
//   cnt_width()    width of an iteration counter that must reach w
package alu_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter has to hold the value w itself, so size it for w+1 states.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/divu_4_seq_if.sv
// Start/busy/done handshake bundle between a controller and the divider.
// Latency: n/a (wires only).
// Backpressure: none; the controller must wait for done before the next start.
//
// Signals:
//   start        controller -> divider, request a division (sampled in IDLE)
//   dividend     controller -> divider, unsigned numerator
//   divisor      controller -> divider, unsigned denominator
//   busy         divider -> controller, high while iterating
//   done         divider -> controller, one-cycle result-valid pulse
//   quotient     divider -> controller, result quotient
//   remainder    divider -> controller, result remainder
//   div_by_zero  divider -> controller, divisor was zero
interface divu_4_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the shifted partial remainder.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports:
//   r_shifted  partial remainder already shifted left with the next dividend bit in bit 0
//   d          divisor, zero-extended to WIDTH+1 bits
//   next_r     partial remainder after the step (restored on borrow)
//   q_bit      quotient bit retired by this step (1 = subtraction fitted)
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0] r_shifted,
    input  logic [WIDTH:0] d,
    output logic [WIDTH:0] next_r,
    output logic           q_bit
);

    // One extra bit on top of the WIDTH+1 operands exposes the borrow.
    logic [WIDTH+1:0] diff;
    logic             borrow;

    assign diff   = {1'b0, r_shifted} - {1'b0, d};
    assign borrow = diff[WIDTH+1];

    // Borrow means the divisor did not fit: keep the shifted value untouched.
    assign next_r = borrow ? r_shifted : diff[WIDTH:0];
    assign q_bit  = ~borrow;

endmodule

// File: rtl/divu_4_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Latency: WIDTH+1 cycles from accepted start to done (1 cycle when divisor is zero).
// Backpressure: start is only honoured in IDLE; starts during RUN/DONE are dropped, not queued.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; wins over everything, an aborted division never raises done
//   bus  slave side of divu_4_seq_if (start/dividend/divisor in, busy/done/results out)
//
// The dividend is held in the Q register and shifted out MSB-first into the
// partial remainder R while quotient bits are shifted into Q's LSB, so after
// WIDTH steps Q holds the quotient and R the remainder.
module divu_4_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    divu_4_seq_if.slave    bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH:0]   r;      // partial remainder, one bit wider than operands
    logic [WIDTH-1:0] q;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] d;      // divisor captured at start
    logic [CW-1:0]    cnt;    // iterations completed in this division

    logic [WIDTH:0]   r_shifted;
    logic [WIDTH:0]   step_r;
    logic             step_q;
    logic [WIDTH-1:0] q_next;

    // Shift {R,Q} left by one. R is always below D here, so its top bit is
    // zero and the shift cannot lose information.
    assign r_shifted = (r << 1) | (WIDTH+1)'(q[WIDTH-1]);
    assign q_next    = {q[WIDTH-2:0], step_q};

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .r_shifted (r_shifted),
        .d         ({1'b0, d}),
        .next_r    (step_r),
        .q_bit     (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            r               <= '0;
            q               <= '0;
            d               <= '0;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            // No iterations needed: report the conventional
                            // all-ones quotient and pass the dividend through.
                            bus.quotient    <= '1;
                            bus.remainder   <= bus.dividend;
                            bus.div_by_zero <= 1'b1;
                            bus.done        <= 1'b1;
                            state           <= ST_DONE;
                        end else begin
                            r               <= '0;
                            q               <= bus.dividend;
                            d               <= bus.divisor;
                            cnt             <= '0;
                            bus.div_by_zero <= 1'b0;
                            bus.busy        <= 1'b1;
                            state           <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    r   <= step_r;
                    q   <= q_next;
                    cnt <= cnt + CW'(1);
                    // This edge retires the last quotient bit, so publish
                    // the freshly computed values rather than the registers.
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.quotient  <= q_next;
                        bus.remainder <= step_r[WIDTH-1:0];
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // done lasts exactly one cycle; start is ignored here.
                    bus.done <= 1'b0;
                    state    <= ST_IDLE;
                end

                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divu_4_seq.sv
// Directed bench for divu_4_seq: reset state, single divisions, divide by zero,
// ignored start during RUN, reset mid-RUN and an exhaustive 4-bit sweep.
// Inputs change 1ns after the rising edge; outputs are sampled at that point too.
module tb_divu_4_seq;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    divu_4_seq_if #(.WIDTH(W)) bus_if ();

    divu_4_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse, then watch up to 20 cycles for done.
    // done_at is the cycle (1 = cycle after the start edge) done was seen, 0 on timeout.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output int done_at, output int busy_cnt);
        bus_if.start    = 1'b1;
        bus_if.dividend = a;
        bus_if.divisor  = b;
        tick();
        bus_if.start = 1'b0;
        done_at  = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (bus_if.busy === 1'b1) busy_cnt++;
            if (bus_if.done === 1'b1) begin
                done_at = c;
                break;
            end
            tick();
        end
    endtask

    // One division with full checking; returns in the cycle after done,
    // which is the earliest cycle a new start may be driven.
    task automatic test_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                            input int elat, input int ebusy);
        int done_at;
        int busy_cnt;
        run_div(a, b, done_at, busy_cnt);
        n_vec++;
        if (done_at !== elat) begin
            n_err++;
            $display("FAIL %s %0d/%0d done cycle: got %0d want %0d", tag, a, b, done_at, elat);
        end
        n_vec++;
        if (busy_cnt !== ebusy) begin
            n_err++;
            $display("FAIL %s %0d/%0d busy cycles: got %0d want %0d", tag, a, b, busy_cnt, ebusy);
        end
        n_vec++;
        if (bus_if.quotient !== eq) begin
            n_err++;
            $display("FAIL %s %0d/%0d quotient: got %0d want %0d", tag, a, b, bus_if.quotient, eq);
        end
        n_vec++;
        if (bus_if.remainder !== er) begin
            n_err++;
            $display("FAIL %s %0d/%0d remainder: got %0d want %0d", tag, a, b, bus_if.remainder, er);
        end
        n_vec++;
        if (bus_if.div_by_zero !== edbz) begin
            n_err++;
            $display("FAIL %s %0d/%0d div_by_zero: got %0b want %0b", tag, a, b, bus_if.div_by_zero, edbz);
        end
        tick();
        n_vec++;
        if (bus_if.done !== 1'b0) begin
            n_err++;
            $display("FAIL %s %0d/%0d done width: done still %0b one cycle later", tag, a, b, bus_if.done);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        n_vec++;
        if (bus_if.busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy: got %0b want 0", tag, bus_if.busy);
        end
        n_vec++;
        if (bus_if.done !== 1'b0) begin
            n_err++;
            $display("FAIL %s done: got %0b want 0", tag, bus_if.done);
        end
        n_vec++;
        if (bus_if.quotient !== '0) begin
            n_err++;
            $display("FAIL %s quotient: got %0d want 0", tag, bus_if.quotient);
        end
        n_vec++;
        if (bus_if.remainder !== '0) begin
            n_err++;
            $display("FAIL %s remainder: got %0d want 0", tag, bus_if.remainder);
        end
        n_vec++;
        if (bus_if.div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL %s div_by_zero: got %0b want 0", tag, bus_if.div_by_zero);
        end
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus_if.start    = 1'b0;
        bus_if.dividend = '0;
        bus_if.divisor  = '0;
        tick();
        tick();
        check_idle_zero("reset");
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        test_div("basic", 4'd13, 4'd3, 4'd4,  4'd1, 1'b0, 5, 4);
        test_div("basic", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5, 4);
        test_div("basic", 4'd3,  4'd5, 4'd0,  4'd3, 1'b0, 5, 4);
        test_div("basic", 4'd8,  4'd8, 4'd1,  4'd0, 1'b0, 5, 4);
    endtask

    task automatic test_div_by_zero();
        test_div("divzero", 4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 1, 0);
        test_div("after_divzero", 4'd6, 4'd2, 4'd3, 4'd0, 1'b0, 5, 4);
    endtask

    task automatic test_ignored_start();
        int n_done = 0;
        logic [W-1:0] q_seen = '0;
        logic [W-1:0] r_seen = '0;
        bus_if.start    = 1'b1;
        bus_if.dividend = 4'd14;
        bus_if.divisor  = 4'd4;
        tick();
        // First RUN cycle: a second start with different operands.
        bus_if.dividend = 4'd7;
        bus_if.divisor  = 4'd7;
        tick();
        bus_if.start    = 1'b0;
        bus_if.dividend = 4'd1;
        bus_if.divisor  = 4'd1;
        for (int c = 0; c < 12; c++) begin
            if (bus_if.done === 1'b1) begin
                n_done++;
                q_seen = bus_if.quotient;
                r_seen = bus_if.remainder;
            end
            tick();
        end
        n_vec++;
        if (n_done !== 1) begin
            n_err++;
            $display("FAIL ignore done count: got %0d want 1", n_done);
        end
        n_vec++;
        if (q_seen !== 4'd3) begin
            n_err++;
            $display("FAIL ignore quotient: got %0d want 3", q_seen);
        end
        n_vec++;
        if (r_seen !== 4'd2) begin
            n_err++;
            $display("FAIL ignore remainder: got %0d want 2", r_seen);
        end
    endtask

    task automatic test_reset_mid_run();
        int n_done = 0;
        bus_if.start    = 1'b1;
        bus_if.dividend = 4'd12;
        bus_if.divisor  = 4'd5;
        tick();
        bus_if.start = 1'b0;
        tick();
        // Now in the second RUN cycle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_zero("reset_mid");
        for (int c = 0; c < 8; c++) begin
            if (bus_if.done === 1'b1) n_done++;
            tick();
        end
        n_vec++;
        if (n_done !== 0) begin
            n_err++;
            $display("FAIL reset_mid aborted done count: got %0d want 0", n_done);
        end
        test_div("after_reset", 4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 5, 4);
    endtask

    task automatic test_sweep();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                a = W'(i);
                b = W'(j);
                if (j == 0) begin
                    test_div("sweep", a, b, 4'hF, a, 1'b1, 1, 0);
                end else begin
                    eq = W'(i / j);
                    er = W'(i % j);
                    test_div("sweep", a, b, eq, er, 1'b0, 5, 4);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_by_zero();
        test_ignored_start();
        test_reset_mid_run();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
